// File: rtl/tx_uart.sv
// UART transmitter: serialises buffered bytes as start / LSB-first data / stop frames.
// Latency: a write at edge N into an empty idle block drives the start bit from edge N+2.
// Backpressure: none upstream; a write into a full buffer is dropped and sets sticky out_overflow.
//
// Ports:
//   clk           single clock, all logic on posedge
//   i_reset       synchronous active-high reset; aborts any frame in flight
//   in_start_tx   one-cycle write strobe qualifying in_data
//   in_data       BW-1 bit payload
//   out_busy      registered: frame in progress or byte buffered
//   out_overflow  sticky: a write was dropped because the buffer was full
//   uart_rxd_out  registered serial line, idle high
//
// Build option: define TX_UART_FIFO_EN for a 2**FIFO_AW deep FIFO; otherwise a
// single holding register buffers one byte.
module tx_uart #(
  parameter int                    BW              = 9,
  parameter int                    TIMER_BITS      = 32,
  parameter logic [TIMER_BITS-1:0] CLOCKS_PER_BAUD = 868,
  parameter int                    FIFO_AW         = 2
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          in_start_tx,
  input  logic [BW-2:0] in_data,
  output logic          out_busy,
  output logic          out_overflow,
  output logic          uart_rxd_out
);

  if (BW < 2) begin : g_bw_chk
    $error("tx_uart: BW must be at least 2");
  end
  if (FIFO_AW < 1) begin : g_aw_chk
    $error("tx_uart: FIFO_AW must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int                    IW          = (BW > 2) ? $clog2(BW - 1) : 1;
  localparam logic [IW-1:0]         LAST_BIT    = IW'(BW - 2);
  localparam logic [TIMER_BITS-1:0] BAUD_RELOAD = CLOCKS_PER_BAUD - 1'b1;

  state_t                  state;
  logic [TIMER_BITS-1:0]   baud_cnt;
  logic [IW-1:0]           bit_cnt;
  logic [BW-2:0]           shreg;
  logic                    baud_done;

  logic                    buf_empty;
  logic                    buf_full;
  logic [BW-2:0]           buf_dat;
  logic                    pop;
  logic                    accept;

  assign baud_done = (baud_cnt == '0);
  // Pop only from registered occupancy, so a byte written this cycle into an
  // empty buffer is never bypassed straight into the shifter.
  assign pop       = !buf_empty && ((state == IDLE) || (state == STOP && baud_done));
  // A full buffer still takes a write when the same cycle frees a slot.
  assign accept    = in_start_tx && (!buf_full || pop);

`ifdef TX_UART_FIFO_EN
  localparam int DEPTH = 2 ** FIFO_AW;

  logic [BW-2:0]    mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;

  assign buf_empty = (count == '0);
  assign buf_full  = (count == (FIFO_AW + 1)'(DEPTH));
  assign buf_dat   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!i_reset && accept) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
`else
  logic [BW-2:0] hold_dat;
  logic          hold_vld;

  assign buf_empty = !hold_vld;
  assign buf_full  = hold_vld;
  assign buf_dat   = hold_dat;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      hold_vld <= 1'b0;
    end else if (accept) begin
      hold_vld <= 1'b1;
      hold_dat <= in_data;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      uart_rxd_out <= 1'b1;
      out_busy     <= 1'b0;
      out_overflow <= 1'b0;
    end else begin
      // Line and busy follow the registered state one edge later, so every
      // bit keeps its full baud period including across frame boundaries.
      case (state)
        START:   uart_rxd_out <= 1'b0;
        DATA:    uart_rxd_out <= shreg[0];
        default: uart_rxd_out <= 1'b1;
      endcase
      out_busy <= (state != IDLE) || !buf_empty;

      if (in_start_tx && !accept) begin
        out_overflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START;
            shreg    <= buf_dat;
            baud_cnt <= BAUD_RELOAD;
          end
        end
        START: begin
          if (baud_done) begin
            state    <= DATA;
            bit_cnt  <= '0;
            baud_cnt <= BAUD_RELOAD;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            if (pop) begin
              state    <= START;
              shreg    <= buf_dat;
              baud_cnt <= BAUD_RELOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_uart.sv
module tb_tx_uart;

  localparam int BW  = 9;
  localparam int CPB = 16;
  localparam int FRAME = CPB * (BW + 1);

  logic       clk = 1'b0;
  logic       i_reset;
  logic       in_start_tx;
  logic [7:0] in_data;
  logic       out_busy;
  logic       out_overflow;
  logic       uart_rxd_out;

  int cyc    = 0;
  int checks = 0;
  int passes = 0;

  tx_uart #(
    .BW              (BW),
    .TIMER_BITS      (32),
    .CLOCKS_PER_BAUD (32'(CPB)),
    .FIFO_AW         (2)
  ) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .in_start_tx  (in_start_tx),
    .in_data      (in_data),
    .out_busy     (out_busy),
    .out_overflow (out_overflow),
    .uart_rxd_out (uart_rxd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Writes n bytes (v[7:0] first) on consecutive clock edges.
  task automatic write_burst(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_start_tx = 1'b1;
      in_data     = v[8*i +: 8];
    end
    @(negedge clk);
    in_start_tx = 1'b0;
    in_data     = 8'h00;
  endtask

  // Serial receiver: waits for a falling line, samples mid-bit.
  // Returns at the middle of the stop bit.
  task automatic rx_frame(output logic [7:0] b, output int fall, output bit fok, output bit seen);
    seen = 1'b0;
    fok  = 1'b1;
    b    = 8'h00;
    fall = -1;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (uart_rxd_out === 1'b0) begin
        seen = 1'b1;
        fall = cyc;
      end
    end
    if (!seen) return;
    repeat (CPB / 2) @(negedge clk);
    if (uart_rxd_out !== 1'b0) fok = 1'b0;
    for (int i = 0; i < BW - 1; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = uart_rxd_out;
    end
    repeat (CPB) @(negedge clk);
    if (uart_rxd_out !== 1'b1) fok = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (out_busy === 1'b0 && uart_rxd_out === 1'b1) ok = 1'b1;
    end
  endtask

  // Counts cycles with line low or busy high over a window.
  task automatic watch_quiet(input int n, output int lows, output int busys);
    lows  = 0;
    busys = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_rxd_out !== 1'b1) lows++;
      if (out_busy !== 1'b0) busys++;
    end
  endtask

  task automatic test_reset;
    int lows, busys;
    i_reset     = 1'b1;
    in_start_tx = 1'b1;
    in_data     = 8'hFF;
    repeat (5) @(negedge clk);
    checks++;
    if (uart_rxd_out !== 1'b1) $display("FAIL reset_line: got %b expected 1", uart_rxd_out);
    else passes++;
    checks++;
    if (out_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", out_busy);
    else passes++;
    checks++;
    if (out_overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", out_overflow);
    else passes++;
    in_start_tx = 1'b0;
    in_data     = 8'h00;
    i_reset     = 1'b0;
    watch_quiet(40, lows, busys);
    checks++;
    if (lows !== 0 || busys !== 0)
      $display("FAIL reset_ignores_write: got %0d low / %0d busy cycles expected 0/0", lows, busys);
    else passes++;
  endtask

  task automatic test_single;
    logic [9:0] fr;
    int n, c, t, line_err, busy_err;
    bit exp_line, exp_busy, ok;
    fr = {1'b1, 8'h55, 1'b0};
    line_err = 0;
    busy_err = 0;
    @(negedge clk);
    in_start_tx = 1'b1;
    in_data     = 8'h55;
    @(negedge clk);
    in_start_tx = 1'b0;
    n = cyc;
    for (int k = 0; k <= FRAME + 10; k++) begin
      if (k > 0) @(negedge clk);
      c = cyc;
      t = c - (n + 2);
      exp_line = (t < 0 || t >= FRAME) ? 1'b1 : fr[t / CPB];
      exp_busy = (c >= n + 1) && (c < n + 2 + FRAME);
      if (uart_rxd_out !== exp_line) line_err++;
      if (out_busy !== exp_busy) busy_err++;
    end
    checks++;
    if (line_err !== 0) $display("FAIL single_wave: got %0d wrong line cycles expected 0", line_err);
    else passes++;
    checks++;
    if (busy_err !== 0) $display("FAIL single_busy: got %0d wrong busy cycles expected 0", busy_err);
    else passes++;
    wait_idle(ok);
    checks++;
    if (!ok) $display("FAIL single_idle: got busy expected idle");
    else passes++;
  endtask

  task automatic test_latency;
    logic [7:0] bits;
    bit ok;
    @(negedge clk);
    in_start_tx = 1'b1;
    in_data     = 8'hA3;
    @(negedge clk);
    in_start_tx = 1'b0;
    @(negedge clk);
    checks++;
    if (uart_rxd_out !== 1'b1) $display("FAIL latency_n1: got %b expected 1", uart_rxd_out);
    else passes++;
    @(negedge clk);
    checks++;
    if (uart_rxd_out !== 1'b0) $display("FAIL latency_n2: got %b expected 0", uart_rxd_out);
    else passes++;
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      bits[i] = uart_rxd_out;
    end
    // A3 on the wire LSB first: 1,1,0,0,0,1,0,1
    checks++;
    if (bits !== 8'b1010_0011) $display("FAIL latency_bits: got %h expected a3", bits);
    else passes++;
    wait_idle(ok);
    checks++;
    if (!ok) $display("FAIL latency_idle: got busy expected idle");
    else passes++;
  endtask

  task automatic test_back_to_back;
    int n;
    int fall [4];
    bit ok;
`ifdef TX_UART_FIFO_EN
    n = 4;
`else
    n = 2;
`endif
    fork
      write_burst(64'h04_03_02_01, n);
      begin
        logic [7:0] got;
        bit fok, seen;
        for (int i = 0; i < n; i++) begin
          rx_frame(got, fall[i], fok, seen);
          checks++;
          if (!seen || !fok || got !== 8'(i + 1))
            $display("FAIL b2b_data%0d: got %h (seen %b framing %b) expected %h", i, got, seen, fok, 8'(i + 1));
          else passes++;
          checks++;
          if (fall[i] - fall[0] !== FRAME * i)
            $display("FAIL b2b_gap%0d: got offset %0d expected %0d", i, fall[i] - fall[0], FRAME * i);
          else passes++;
        end
      end
    join
    checks++;
    if (out_overflow !== 1'b0) $display("FAIL b2b_overflow: got %b expected 0", out_overflow);
    else passes++;
    wait_idle(ok);
    checks++;
    if (!ok) $display("FAIL b2b_idle: got busy expected idle");
    else passes++;
  endtask

  task automatic burst_expect(input string name, input logic [63:0] v, input int nw,
                              input int nrx, input logic exp_ovf);
    int lows, busys;
    bit ok;
    fork
      write_burst(v, nw);
      begin
        logic [7:0] got;
        int f;
        bit fok, seen;
        for (int i = 0; i < nrx; i++) begin
          rx_frame(got, f, fok, seen);
          checks++;
          if (!seen || !fok || got !== v[8*i +: 8])
            $display("FAIL %s_data%0d: got %h (seen %b framing %b) expected %h", name, i, got, seen, fok, v[8*i +: 8]);
          else passes++;
        end
      end
    join
    checks++;
    if (out_overflow !== exp_ovf) $display("FAIL %s_overflow: got %b expected %b", name, out_overflow, exp_ovf);
    else passes++;
    wait_idle(ok);
    watch_quiet(200, lows, busys);
    checks++;
    if (!ok || lows !== 0 || busys !== 0)
      $display("FAIL %s_extra: got idle %b low %0d busy %0d expected idle with no extra frame", name, ok, lows, busys);
    else passes++;
  endtask

  task automatic test_overflow;
`ifdef TX_UART_FIFO_EN
    burst_expect("ovf6", 64'h16_15_14_13_12_11, 6, 5, 1'b1);
`else
    burst_expect("ovf2", 64'h22_21, 2, 2, 1'b0);
    burst_expect("ovf3", 64'h33_32_31, 3, 2, 1'b1);
`endif
  endtask

  task automatic test_reset_midframe;
    bit seen;
    int lows, busys;
    seen = 1'b0;
    @(negedge clk);
    in_start_tx = 1'b1;
    in_data     = 8'h00;
    @(negedge clk);
    in_start_tx = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (uart_rxd_out === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) $display("FAIL midrst_start: got no start bit expected one");
    else passes++;
    // Data bit 3 occupies offsets 64..79 from the falling edge.
    repeat (70) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    checks++;
    if (uart_rxd_out !== 1'b1 || out_busy !== 1'b0 || out_overflow !== 1'b0)
      $display("FAIL midrst_state: got line %b busy %b ovf %b expected 1 0 0", uart_rxd_out, out_busy, out_overflow);
    else passes++;
    i_reset = 1'b0;
    watch_quiet(300, lows, busys);
    checks++;
    if (lows !== 0 || busys !== 0)
      $display("FAIL midrst_quiet: got %0d low / %0d busy cycles expected 0/0", lows, busys);
    else passes++;
  endtask

  task automatic test_loopback;
    logic [23:0] vals;
    logic [7:0]  got;
    int f;
    bit fok, seen, ok;
    vals = 24'h5A_FF_00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_start_tx = 1'b1;
      in_data     = vals[8*i +: 8];
      @(negedge clk);
      in_start_tx = 1'b0;
      rx_frame(got, f, fok, seen);
      checks++;
      if (!seen || !fok || got !== vals[8*i +: 8])
        $display("FAIL loopback%0d: got %h (seen %b framing %b) expected %h", i, got, seen, fok, vals[8*i +: 8]);
      else passes++;
      wait_idle(ok);
    end
  endtask

  initial begin
    i_reset     = 1'b1;
    in_start_tx = 1'b0;
    in_data     = 8'h00;
    test_reset;
    test_single;
    test_latency;
    test_back_to_back;
    test_overflow;
    test_reset_midframe;
    test_loopback;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
